// File: rtl/mld_15_7_pkg.sv
// Shared sizing constants and FSM state encoding for the (15,7) encoder controller.
package mld_15_7_pkg;

    localparam int unsigned N     = 15;
    localparam int unsigned K     = 7;
    localparam int unsigned CNT_W = $clog2(N);

    typedef logic [2:0] state_t;

    localparam state_t st_idle   = 3'd0;
    localparam state_t st_clear  = 3'd1;
    localparam state_t st_info   = 3'd2;
    localparam state_t st_parity = 3'd3;
    localparam state_t st_done   = 3'd4;

endpackage

// File: rtl/mld_15_7_cw_collector.sv
// N-bit shift-in register gathering the serial codeword; first bit ends up at the MSB.
module mld_15_7_cw_collector #(
    parameter int unsigned N = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic         din,
    output logic [N-1:0] dout
);

    logic [N-1:0] sr;

    // Clear has priority over shifting; reset is synchronous active-low.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sr <= '0;
        end else if (clr) begin
            sr <= '0;
        end else if (en) begin
            sr <= {sr[N-2:0], din};
        end
    end

    assign dout = sr;

endmodule

// File: rtl/mld_15_7_enc_controller.sv
// Sequences one message through an external serial systematic encoder and
// streams the resulting codeword out, also collecting it in parallel.
module mld_15_7_enc_controller
    import mld_15_7_pkg::*;
#(
    parameter int unsigned N = mld_15_7_pkg::N,
    parameter int unsigned K = mld_15_7_pkg::K
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         msg_valid,
    input  logic [K-1:0] msg_data,
    output logic         msg_ready,
    output logic         enc_rst,
    output logic         info_bit,
    output logic         sel,
    input  logic         enc_out,
    output logic         tx_bit,
    output logic         tx_valid,
    output logic         tx_sof,
    output logic         tx_eof,
    output logic [N-1:0] cw_data,
    output logic         cw_valid,
    output logic         busy
);

    localparam int unsigned CW = $clog2(N);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [K-1:0]  sr;
    logic          in_ph;

    assign in_ph = (state == st_info) || (state == st_parity);

    // Main FSM. DONE spends two cycles: the first lets the last parity bit land
    // in the collector, the second presents cw_valid (cnt selects which).
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= st_idle;
            cnt   <= '0;
            sr    <= '0;
        end else begin
            case (state)
                st_idle: begin
                    if (msg_valid) begin
                        sr    <= msg_data;
                        state <= st_clear;
                    end
                end
                st_clear: begin
                    cnt   <= '0;
                    state <= st_info;
                end
                st_info: begin
                    sr  <= {sr[K-2:0], 1'b0};
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(K - 1)) begin
                        state <= st_parity;
                    end
                end
                st_parity: begin
                    if (cnt == CW'(N - 1)) begin
                        cnt   <= '0;
                        state <= st_done;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                st_done: begin
                    if (cnt == '0) begin
                        cnt <= CW'(1);
                    end else begin
                        cnt   <= '0;
                        state <= st_idle;
                    end
                end
                default: state <= st_idle;
            endcase
        end
    end

    // Registered channel stream: encoder output is delayed one cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_bit   <= 1'b0;
            tx_valid <= 1'b0;
            tx_sof   <= 1'b0;
            tx_eof   <= 1'b0;
        end else begin
            tx_bit   <= in_ph & enc_out;
            tx_valid <= in_ph;
            tx_sof   <= (state == st_info) && (cnt == '0);
            tx_eof   <= (state == st_parity) && (cnt == CW'(N - 1));
        end
    end

    mld_15_7_cw_collector #(
        .N (N)
    ) u_collector (
        .clk   (clk),
        .reset (reset),
        .clr   (state == st_clear),
        .en    (in_ph),
        .din   (enc_out),
        .dout  (cw_data)
    );

    // Decoded outputs; gated by reset so they take reset values immediately.
    always_comb begin
        msg_ready = reset && (state == st_idle);
        enc_rst   = !reset || (state == st_clear);
        sel       = reset && (state == st_parity);
        info_bit  = reset && (state == st_info) && sr[K-1];
        busy      = reset && (state != st_idle);
        cw_valid  = reset && (state == st_done) && (cnt != '0);
    end

endmodule

// File: tb/tb_mld_15_7_enc_controller.sv
// Self-checking bench: serial encoder model as environment, cycle-accurate
// latency model derived from the accept time, plus literal golden codewords.
module tb_mld_15_7_enc_controller;

    localparam int N = 15;
    localparam int K = 7;

    logic         clk = 1'b0;
    logic         reset;
    logic         msg_valid;
    logic [K-1:0] msg_data;
    logic         msg_ready, enc_rst, info_bit, sel, enc_out;
    logic         tx_bit, tx_valid, tx_sof, tx_eof, cw_valid, busy;
    logic [N-1:0] cw_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    mld_15_7_enc_controller #(
        .N (N),
        .K (K)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .msg_valid (msg_valid),
        .msg_data  (msg_data),
        .msg_ready (msg_ready),
        .enc_rst   (enc_rst),
        .info_bit  (info_bit),
        .sel       (sel),
        .enc_out   (enc_out),
        .tx_bit    (tx_bit),
        .tx_valid  (tx_valid),
        .tx_sof    (tx_sof),
        .tx_eof    (tx_eof),
        .cw_data   (cw_data),
        .cw_valid  (cw_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) cyc <= cyc + 1;

    // Serial systematic encoder for g(x)=x^8+x^7+x^6+x^4+1 (environment model).
    logic [7:0] lfsr;
    logic       fb;
    assign fb      = info_bit ^ lfsr[7];
    assign enc_out = sel ? lfsr[7] : info_bit;

    always_ff @(posedge clk) begin
        if (enc_rst)  lfsr <= 8'h00;
        else if (sel) lfsr <= {lfsr[6:0], 1'b0};
        else          lfsr <= {lfsr[6:0], 1'b0} ^ (fb ? 8'hD1 : 8'h00);
    end

    // Remainder of a 15-bit polynomial modulo g(x).
    function automatic logic [7:0] pmod(input logic [14:0] v);
        logic [14:0] t;
        t = v;
        for (int i = 14; i >= 8; i--) begin
            if (t[i]) t = t ^ (15'h1D1 << (i - 8));
        end
        return t[7:0];
    endfunction

    function automatic logic [14:0] enc_ref(input logic [6:0] m);
        return {m, pmod({m, 8'h00})};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: all expectations follow from cycles elapsed since accept.
    logic         active       = 1'b0;
    logic         prev_rst_low = 1'b1;
    int           tacc         = 0;
    int           sel_cnt      = 0;
    logic [N-1:0] cw_exp       = '0;

    always @(negedge clk) begin
        int         d;
        logic [5:0] ec;
        logic [3:0] er;
        if (!reset) begin
            chk("reset_ctl", {26'd0, msg_ready, busy, enc_rst, sel, info_bit, cw_valid},
                32'b001000);
            if (prev_rst_low) begin
                chk("reset_tx", {28'd0, tx_valid, tx_bit, tx_sof, tx_eof}, 32'd0);
                chk("reset_cw_data", {17'd0, cw_data}, 32'd0);
            end
            active       = 1'b0;
            prev_rst_low = 1'b1;
        end else begin
            d = cyc - tacc;
            if (active && d >= 19) active = 1'b0;
            ec[5] = !active;
            ec[4] = active && d >= 1 && d <= 18;
            ec[3] = active && d == 1;
            ec[2] = active && d >= 9 && d <= 16;
            ec[1] = (active && d >= 2 && d <= 8) ? cw_exp[N - 1 - (d - 2)] : 1'b0;
            ec[0] = active && d == 18;
            er[3] = active && d >= 3 && d <= 17;
            er[2] = er[3] ? cw_exp[N - 1 - (d - 3)] : 1'b0;
            er[1] = active && d == 3;
            er[0] = active && d == 17;
            chk("ctl_outs", {26'd0, msg_ready, busy, enc_rst, sel, info_bit, cw_valid},
                {26'd0, ec});
            chk("tx_outs", {28'd0, tx_valid, tx_bit, tx_sof, tx_eof}, {28'd0, er});
            if (prev_rst_low) chk("cw_data_after_reset", {17'd0, cw_data}, 32'd0);
            if (active && d == 18) begin
                chk("cw_data", {17'd0, cw_data}, {17'd0, cw_exp});
                chk("cw_divisible", {24'd0, pmod(cw_data)}, 32'd0);
                chk("sel_cycles", sel_cnt, 8);
            end
            if (sel) sel_cnt++;
            if (!active && msg_valid) begin
                active  = 1'b1;
                tacc    = cyc;
                cw_exp  = enc_ref(msg_data);
                sel_cnt = 0;
            end
            prev_rst_low = 1'b0;
        end
    end

    // Capture of the serial stream for the literal golden checks.
    logic [N-1:0] cap = '0, last_cap = '0, last_cw = '0;
    int           sof_n = 0, eof_n = 0, last_sof = 0, last_eof = 0, cw_cnt = 0;

    always @(negedge clk) begin
        if (!reset) begin
            cap   = '0;
            sof_n = 0;
            eof_n = 0;
        end else begin
            if (tx_valid) cap = {cap[N-2:0], tx_bit};
            if (tx_sof) sof_n++;
            if (tx_eof) eof_n++;
            if (cw_valid) begin
                last_cap = cap;
                last_cw  = cw_data;
                last_sof = sof_n;
                last_eof = eof_n;
                cap      = '0;
                sof_n    = 0;
                eof_n    = 0;
                cw_cnt++;
            end
        end
    end

    // Offer m until accepted; returns the accept cycle, leaves msg_valid high.
    task automatic send(input logic [K-1:0] m, output int t);
        int n = 0;
        msg_valid = 1'b1;
        msg_data  = m;
        @(negedge clk);
        while (!msg_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: msg_ready stayed 0, expected 1 within 100 cycles");
        end
        t = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cw();
        int start = cw_cnt;
        int n     = 0;
        while (cw_cnt == start && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL cw_timeout: cw_valid not seen, expected within 100 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t1, t2;
        logic [K-1:0] m;
        reset     = 1'b0;
        msg_valid = 1'b0;
        msg_data  = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Single-bit message: golden stream and codeword.
        send(7'h40, t1);
        msg_valid = 1'b0;
        wait_cw();
        chk("g40_stream", {17'd0, last_cap}, {17'd0, 15'b100000011101000});
        chk("g40_cw_data", {17'd0, last_cw}, {17'd0, 15'b100000011101000});
        chk("g40_sof", last_sof, 1);
        chk("g40_eof", last_eof, 1);

        // All-zero message.
        send(7'h00, t1);
        msg_valid = 1'b0;
        wait_cw();
        chk("g00_stream", {17'd0, last_cap}, 32'd0);
        chk("g00_sof", last_sof, 1);
        chk("g00_eof", last_eof, 1);

        // Back-to-back with msg_valid held high.
        send(7'h40, t1);
        send(7'h7F, t2);
        msg_valid = 1'b0;
        chk("b2b_interval", t2 - t1, 19);
        wait_cw();
        chk("g7f_stream", {17'd0, last_cap}, {17'd0, enc_ref(7'h7F)});

        // msg_valid toggling while busy must be ignored.
        m = 7'($urandom);
        send(m, t1);
        repeat (8) begin
            msg_valid = 1'($urandom);
            msg_data  = 7'($urandom);
            @(posedge clk);
            #1;
        end
        msg_valid = 1'b0;
        wait_cw();
        chk("toggle_stream", {17'd0, last_cap}, {17'd0, enc_ref(m)});

        // Reset in the fifth parity cycle aborts the codeword.
        t2 = cw_cnt;
        send(7'($urandom), t1);
        msg_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_cw_valid", cw_cnt, t2);
        m = 7'h55;
        send(m, t1);
        msg_valid = 1'b0;
        wait_cw();
        chk("post_reset_stream", {17'd0, last_cap}, {17'd0, enc_ref(7'h55)});

        // Sweep all messages with msg_valid held high.
        for (int i = 0; i < 128; i++) send(7'(i), t1);
        msg_valid = 1'b0;
        wait_cw();

        // Random messages with random idle gaps.
        for (int i = 0; i < 20; i++) begin
            send(7'($urandom), t1);
            msg_valid = 1'b0;
            repeat ($urandom_range(0, 20)) @(posedge clk);
            #1;
        end
        wait_cw();
        repeat (5) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
